raster_counter: RTL and testbench

Two-dimensional pixel-position counter for the Sobel datapath. It tracks the column and row of the next pixel accepted on a valid/ready stream, along with a frame count. It raises line and frame boundary flags for the line buffers and window generator. Compared with the single-axis counter it replaces, it adds cascaded axes, runtime-programmable frame size, a wrap/halt end-of-frame mode, and a synchronous clear.

---
 rtl/raster_counter_pkg.sv | 14 +
 rtl/raster_counter_bounded_counter.sv | 28 ++
 rtl/raster_counter.sv | 113 +++++++++++
 tb/tb_raster_counter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/raster_counter_pkg.sv
// Shared types and default frame dimensions for the raster counter and the
// line buffers that size themselves from the same geometry.
package raster_counter_pkg;

   typedef enum logic {MODE_WRAP, MODE_HALT} cnt_mode_e;
   typedef enum logic {ST_RUN, ST_HALT} cnt_state_e;

   localparam int DEF_COL_WIDTH   = 11;
   localparam int DEF_ROW_WIDTH   = 11;
   localparam int DEF_COLS        = 640;
   localparam int DEF_ROWS        = 480;
   localparam int DEF_FRAME_WIDTH = 16;

endpackage

// File: rtl/raster_counter_bounded_counter.sv
// One counter axis that wraps to zero after reaching limit_i-1; at_max_o is
// combinational so the next axis can cascade off it in the same cycle.
module bounded_counter #(
   parameter int WIDTH_P = 11
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               inc_i,
   input  logic               clr_i,
   input  logic [WIDTH_P-1:0] limit_i,
   output logic [WIDTH_P-1:0] count_o,
   output logic               at_max_o
);

   localparam logic [WIDTH_P-1:0] ONE = WIDTH_P'(1);

   assign at_max_o = (count_o == limit_i - ONE);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         count_o <= '0;
      else if (clr_i)
         count_o <= '0;
      else if (inc_i)
         count_o <= at_max_o ? '0 : count_o + ONE;
   end

endmodule

// File: rtl/raster_counter.sv
// Column/row/frame position tracker for a valid/ready pixel stream with
// boundary flags, programmable frame size and wrap/halt end-of-frame modes.
module raster_counter
   import raster_counter_pkg::*;
#(
   parameter int COL_WIDTH_P   = DEF_COL_WIDTH,
   parameter int ROW_WIDTH_P   = DEF_ROW_WIDTH,
   parameter int COLS_P        = DEF_COLS,
   parameter int ROWS_P        = DEF_ROWS,
   parameter int FRAME_WIDTH_P = DEF_FRAME_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clear_i,
   input  logic                     mode_i,
   input  logic [COL_WIDTH_P-1:0]   cols_i,
   input  logic [ROW_WIDTH_P-1:0]   rows_i,
   input  logic                     valid_i,
   input  logic                     ready_i,
   output logic                     ready_o,
   output logic [COL_WIDTH_P-1:0]   col_o,
   output logic [ROW_WIDTH_P-1:0]   row_o,
   output logic [FRAME_WIDTH_P-1:0] frame_o,
   output logic                     sol_o,
   output logic                     eol_o,
   output logic                     sof_o,
   output logic                     eof_o,
   output logic                     line_done_o,
   output logic                     frame_done_o,
   output logic                     halted_o
);

   cnt_state_e             state, state_nxt;
   logic [COL_WIDTH_P-1:0] cols_l;
   logic [ROW_WIDTH_P-1:0] rows_l;
   logic                   beat, col_inc, row_inc, frame_wrap;
   logic                   col_max, row_max;

   // clear_i wins over a beat, so gating the increment also suppresses pulses
   assign beat       = valid_i & ready_o;
   assign col_inc    = beat & ~clear_i;
   assign row_inc    = col_inc & col_max;
   assign frame_wrap = row_inc & row_max;

   bounded_counter #(.WIDTH_P(COL_WIDTH_P)) u_col (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .inc_i    (col_inc),
      .clr_i    (clear_i),
      .limit_i  (cols_l),
      .count_o  (col_o),
      .at_max_o (col_max)
   );

   bounded_counter #(.WIDTH_P(ROW_WIDTH_P)) u_row (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .inc_i    (row_inc),
      .clr_i    (clear_i),
      .limit_i  (rows_l),
      .count_o  (row_o),
      .at_max_o (row_max)
   );

   // Limits only reload at frame boundaries; zero is promoted to one
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cols_l       <= COL_WIDTH_P'(COLS_P);
         rows_l       <= ROW_WIDTH_P'(ROWS_P);
         frame_o      <= '0;
         line_done_o  <= 1'b0;
         frame_done_o <= 1'b0;
      end else begin
         if (clear_i || frame_wrap) begin
            cols_l <= (cols_i == '0) ? COL_WIDTH_P'(1) : cols_i;
            rows_l <= (rows_i == '0) ? ROW_WIDTH_P'(1) : rows_i;
         end
         if (frame_wrap)
            frame_o <= frame_o + FRAME_WIDTH_P'(1);
         line_done_o  <= row_inc;
         frame_done_o <= frame_wrap;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         state <= ST_RUN;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:  if (!clear_i && frame_wrap && cnt_mode_e'(mode_i) == MODE_HALT)
                     state_nxt = ST_HALT;
         ST_HALT: if (clear_i)
                     state_nxt = ST_RUN;
         default: state_nxt = ST_RUN;
      endcase
   end

   always_comb begin
      halted_o = (state == ST_HALT);
      ready_o  = ready_i & (state == ST_RUN);
   end

   assign sol_o = (col_o == '0);
   assign eol_o = col_max;
   assign sof_o = (col_o == '0) && (row_o == '0);
   assign eof_o = col_max & row_max;

endmodule

// File: tb/tb_raster_counter.sv
// Directed checks of raster_counter: frame stepping, backpressure, halt mode,
// mid-frame size change, degenerate 1x1 frames and asynchronous reset.
module tb_raster_counter;

   logic        clk_i = 1'b0;
   logic        rstn_i, clear_i, mode_i, valid_i, ready_i;
   logic [10:0] cols_i, rows_i;
   logic        ready_o, sol_o, eol_o, sof_o, eof_o;
   logic        line_done_o, frame_done_o, halted_o;
   logic [10:0] col_o, row_o;
   logic [15:0] frame_o;

   int n_chk = 0;
   int n_err = 0;

   raster_counter dut (
      .clk_i        (clk_i),
      .rstn_i       (rstn_i),
      .clear_i      (clear_i),
      .mode_i       (mode_i),
      .cols_i       (cols_i),
      .rows_i       (rows_i),
      .valid_i      (valid_i),
      .ready_i      (ready_i),
      .ready_o      (ready_o),
      .col_o        (col_o),
      .row_o        (row_o),
      .frame_o      (frame_o),
      .sol_o        (sol_o),
      .eol_o        (eol_o),
      .sof_o        (sof_o),
      .eof_o        (eof_o),
      .line_done_o  (line_done_o),
      .frame_done_o (frame_done_o),
      .halted_o     (halted_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled 2 time units after each rising edge
   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   task automatic do_clear(input logic [10:0] c, input logic [10:0] r, input logic m);
      cols_i = c; rows_i = r; mode_i = m; clear_i = 1'b1; valid_i = 1'b0;
      step();
      clear_i = 1'b0;
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      step();
      rstn_i = 1'b1;
      step();
   endtask

   int lines, frames, acc, m_col, m_row;

   initial begin
      rstn_i = 1'b0; clear_i = 1'b0; mode_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
      cols_i = 11'd4; rows_i = 11'd3;
      #12;
      // reset state
      chk("rst_col", col_o, 0);
      chk("rst_row", row_o, 0);
      chk("rst_frame", frame_o, 0);
      chk("rst_sol", sol_o, 1);
      chk("rst_sof", sof_o, 1);
      chk("rst_eol", eol_o, 0);
      chk("rst_halted", halted_o, 0);
      chk("rst_line_done", line_done_o, 0);
      chk("rst_frame_done", frame_done_o, 0);
      chk("rst_ready", ready_o, 1);
      rstn_i = 1'b1;
      step();

      // 4x3 WRAP frame, continuous beats
      do_clear(11'd4, 11'd3, 1'b0);
      lines = 0; frames = 0;
      valid_i = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("f1_col", col_o, i % 4);
         chk("f1_row", row_o, i / 4);
         chk("f1_eol", eol_o, (i % 4) == 3);
         chk("f1_eof", eof_o, i == 11);
         step();
         chk("f1_line_done", line_done_o, (i % 4) == 3);
         chk("f1_frame_done", frame_done_o, i == 11);
         lines += line_done_o;
         frames += frame_done_o;
      end
      valid_i = 1'b0;
      chk("f1_lines", lines, 3);
      chk("f1_frames", frames, 1);
      chk("f1_frame_o", frame_o, 1);
      chk("f1_pos", {col_o, row_o}, 0);

      // backpressure: ready_i toggles, 24 beats over 48 cycles
      do_reset();
      do_clear(11'd4, 11'd3, 1'b0);
      m_col = 0; m_row = 0;
      valid_i = 1'b1;
      for (int k = 0; k < 48; k++) begin
         ready_i = (k % 2 == 0);
         #1;
         chk("bp_ready", ready_o, ready_i);
         if (ready_i) begin
            if (m_col == 3) begin
               m_col = 0;
               m_row = (m_row == 2) ? 0 : m_row + 1;
            end else m_col++;
         end
         step();
         chk("bp_col", col_o, m_col);
         chk("bp_row", row_o, m_row);
      end
      valid_i = 1'b0; ready_i = 1'b1;
      chk("bp_frame_o", frame_o, 2);

      // HALT mode, 2x2 frame, 6 beats offered
      do_clear(11'd2, 11'd2, 1'b1);
      acc = 0; frames = 0;
      valid_i = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         acc += ready_o;
         step();
         frames += frame_done_o;
      end
      valid_i = 1'b0;
      chk("halt_accepted", acc, 4);
      chk("halt_frame_done", frames, 1);
      chk("halt_halted", halted_o, 1);
      chk("halt_ready", ready_o, 0);
      chk("halt_pos", {col_o, row_o}, 0);
      chk("halt_frame_o", frame_o, 3);
      do_clear(11'd4, 11'd3, 1'b0);
      chk("unhalt_halted", halted_o, 0);
      chk("unhalt_ready", ready_o, 1);
      chk("unhalt_frame_o", frame_o, 3);
      chk("unhalt_sof", sof_o, 1);

      // size change mid-frame only takes effect at the next frame
      valid_i = 1'b1;
      step();
      cols_i = 11'd2;
      step(); step();
      chk("mid_col", col_o, 3);
      chk("mid_eol", eol_o, 1);
      for (int k = 0; k < 9; k++) step();
      chk("mid_frame_o", frame_o, 4);
      chk("mid_pos", {col_o, row_o}, 0);
      step();
      chk("new_col", col_o, 1);
      chk("new_eol", eol_o, 1);
      step();
      chk("new_wrap_col", col_o, 0);
      chk("new_wrap_row", row_o, 1);
      chk("new_line_done", line_done_o, 1);
      valid_i = 1'b0;

      // zero sizes load as 1x1: every beat ends a line and a frame
      do_clear(11'd0, 11'd0, 1'b0);
      chk("one_pos", {col_o, row_o}, 0);
      chk("one_eol", eol_o, 1);
      chk("one_eof", eof_o, 1);
      valid_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("one_line_done", line_done_o, 1);
         chk("one_frame_done", frame_done_o, 1);
      end
      valid_i = 1'b0;
      step();
      chk("one_frame_o", frame_o, 7);
      chk("one_idle_done", line_done_o, 0);

      // async reset at (2,1) with a beat pending
      do_clear(11'd4, 11'd3, 1'b0);
      valid_i = 1'b1;
      for (int k = 0; k < 6; k++) step();
      chk("ar_pre_pos", {col_o, row_o}, {11'd2, 11'd1});
      rstn_i = 1'b0;
      #1;
      chk("ar_col", col_o, 0);
      chk("ar_row", row_o, 0);
      chk("ar_frame_o", frame_o, 0);
      step();
      chk("ar_line_done", line_done_o, 0);
      chk("ar_frame_done", frame_done_o, 0);
      rstn_i = 1'b1;
      step();
      chk("ar_resume_col", col_o, 1);
      chk("ar_resume_done", line_done_o, 0);
      valid_i = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
